pc_sequencer: RTL and testbench

//   Parametrised program sequencer for the 8-bit CPU core: PC register, call/return stack and a

---
 rtl/pc_sequencer_if.sv | 39 +++
 rtl/pc_sequencer.sv | 175 +++++++++++++++++
 tb/tb_pc_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Control-unit to sequencer bus: flow control, stack commands, interrupt lines and status.
// Latency: none; this is only a bundle of wires.
// Backpressure: none; the sequencer acts on every command in the cycle it is presented.
interface pc_sequencer_if #(
    parameter int AW    = 10,
    parameter int DEPTH = 8,
    parameter int NIRQ  = 4
);
    localparam int SPW = $clog2(DEPTH + 1);

    // control unit -> sequencer
    logic            s_inc;
    logic [AW-1:0]   jump_addr;
    logic            call;
    logic            ret;
    logic            reti;
    logic            ie_set;
    logic            ie_clr;
    logic [NIRQ-1:0] irq;
    logic [NIRQ-1:0] irq_mask;

    // sequencer -> control unit / program memory
    logic [AW-1:0]   pc;
    logic            in_isr;
    logic [NIRQ-1:0] irq_ack;
    logic [SPW-1:0]  sp;
    logic            stack_ovf;
    logic            stack_unf;

    modport master (
        output s_inc, jump_addr, call, ret, reti, ie_set, ie_clr, irq, irq_mask,
        input  pc, in_isr, irq_ack, sp, stack_ovf, stack_unf
    );

    modport slave (
        input  s_inc, jump_addr, call, ret, reti, ie_set, ie_clr, irq, irq_mask,
        output pc, in_isr, irq_ack, sp, stack_ovf, stack_unf
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program sequencer: PC register, call/return stack and vectored interrupt controller.
// Latency: one cycle; every command shows up in pc after the next rising edge.
// Backpressure: none; a full stack keeps interrupts pending and flags overflow on call.
module pc_sequencer #(
    parameter int            AW         = 10,
    parameter int            DEPTH      = 8,
    parameter int            NIRQ       = 4,
    parameter logic [AW-1:0] VEC_BASE   = AW'(10'h384),
    parameter int            VEC_STRIDE = 4
) (
    input  logic          clk,
    input  logic          reset,
    pc_sequencer_if.slave bus
);
    localparam int SPW = $clog2(DEPTH + 1);
    localparam int SIW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW  = (NIRQ > 1) ? $clog2(NIRQ) : 1;

    // architectural state
    logic [AW-1:0]   pc_q;
    logic [SPW-1:0]  sp_q;
    logic [NIRQ-1:0] pending_q;
    logic [NIRQ-1:0] irq_prev_q;
    logic [NIRQ-1:0] ack_q;
    logic            ie_q;
    logic            in_isr_q;
    logic            ovf_q;
    logic            unf_q;
    logic [AW-1:0]   stack [DEPTH];

    // next-state values
    logic [AW-1:0]   pc_nxt;
    logic [SPW-1:0]  sp_nxt;
    logic [NIRQ-1:0] pending_nxt;
    logic [NIRQ-1:0] ack_nxt;
    logic            ie_nxt;
    logic            in_isr_nxt;
    logic            ovf_nxt;
    logic            unf_nxt;

    // datapath helpers
    logic [AW-1:0]   pc_inc;
    logic [AW-1:0]   flow_pc;
    logic [AW-1:0]   vec_addr;
    logic [AW-1:0]   push_val;
    logic [NIRQ-1:0] eligible;
    logic [NIRQ-1:0] take_oh;
    logic [IW-1:0]   take_idx;
    logic            take;
    logic            do_ret;
    logic            stack_full;
    logic            stack_empty;
    logic            push_en;
    logic [SIW-1:0]  push_idx;
    logic [SIW-1:0]  pop_idx;

    assign pc_inc      = pc_q + AW'(1);
    assign flow_pc     = bus.s_inc ? pc_inc : bus.jump_addr;
    assign do_ret      = bus.ret | bus.reti;
    assign stack_full  = (sp_q == SPW'(DEPTH));
    assign stack_empty = (sp_q == '0);
    assign push_idx    = sp_q[SIW-1:0];
    assign pop_idx     = SIW'(sp_q - SPW'(1));

    // Pick the lowest-numbered pending, unmasked line and form its vector address.
    always_comb begin
        eligible = pending_q & bus.irq_mask;
        take_idx = '0;
        take_oh  = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                take_idx = IW'(i);
                take_oh  = NIRQ'(1) << i;
            end
        end
        // Product wraps modulo 2^AW, so truncating the stride first is harmless.
        vec_addr = VEC_BASE + AW'(take_idx) * AW'(VEC_STRIDE);
        // A return in the same cycle finishes first; the vector waits one edge.
        take = ie_q && !in_isr_q && (|eligible) && !stack_full && !do_ret;
    end

    // One action per cycle: interrupt take, then return, then call, then plain flow.
    always_comb begin
        pc_nxt     = flow_pc;
        sp_nxt     = sp_q;
        push_en    = 1'b0;
        push_val   = pc_inc;
        in_isr_nxt = in_isr_q;
        ack_nxt    = '0;
        ovf_nxt    = ovf_q;
        unf_nxt    = unf_q;

        if (take) begin
            // Save where the interrupted flow would have gone; a concurrent call's
            // own return address is dropped and its target becomes the resume point.
            push_en    = 1'b1;
            push_val   = bus.call ? bus.jump_addr : flow_pc;
            sp_nxt     = sp_q + SPW'(1);
            pc_nxt     = vec_addr;
            in_isr_nxt = 1'b1;
            ack_nxt    = take_oh;
        end else if (do_ret) begin
            if (!stack_empty) begin
                pc_nxt = stack[pop_idx];
                sp_nxt = sp_q - SPW'(1);
            end else begin
                unf_nxt = 1'b1;
                pc_nxt  = pc_inc;
            end
            if (bus.reti) begin
                in_isr_nxt = 1'b0;
            end
        end else if (bus.call) begin
            pc_nxt = bus.jump_addr;
            if (!stack_full) begin
                push_en  = 1'b1;
                push_val = pc_inc;
                sp_nxt   = sp_q + SPW'(1);
            end else begin
                ovf_nxt = 1'b1;
            end
        end

        // Clearing ie dominates setting it; both only gate takes from the next cycle.
        if (bus.ie_clr) begin
            ie_nxt = 1'b0;
        end else if (bus.ie_set) begin
            ie_nxt = 1'b1;
        end else begin
            ie_nxt = ie_q;
        end

        // Masking never drops a request; only taking the line clears it.
        pending_nxt = (pending_q & ~ack_nxt) | (bus.irq & ~irq_prev_q);
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q       <= '0;
            sp_q       <= '0;
            pending_q  <= '0;
            irq_prev_q <= '0;
            ack_q      <= '0;
            ie_q       <= 1'b0;
            in_isr_q   <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            pc_q       <= pc_nxt;
            sp_q       <= sp_nxt;
            pending_q  <= pending_nxt;
            irq_prev_q <= bus.irq;
            ack_q      <= ack_nxt;
            ie_q       <= ie_nxt;
            in_isr_q   <= in_isr_nxt;
            ovf_q      <= ovf_nxt;
            unf_q      <= unf_nxt;
        end
    end

    // Return-stack storage; contents are meaningless once sp says so, so no reset.
    always_ff @(posedge clk) begin
        if (reset && push_en) begin
            stack[push_idx] <= push_val;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.sp        = sp_q;
    assign bus.in_isr    = in_isr_q;
    assign bus.irq_ack   = ack_q;
    assign bus.stack_ovf = ovf_q;
    assign bus.stack_unf = unf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed command sequences with a queued expectation per cycle.
// Latency: expectations are popped one edge after the stimulus that produced them.
// Backpressure: none; the sequencer accepts a command every cycle.
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pc_sequencer_if #(.AW(10), .DEPTH(8), .NIRQ(4)) bus ();
    pc_sequencer #(
        .AW(10), .DEPTH(8), .NIRQ(4), .VEC_BASE(10'h384), .VEC_STRIDE(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Narrow build to exercise PC wrap and vector truncation.
    pc_sequencer_if #(.AW(4), .DEPTH(2), .NIRQ(2)) wbus ();
    pc_sequencer #(
        .AW(4), .DEPTH(2), .NIRQ(2), .VEC_BASE(4'hE), .VEC_STRIDE(3)
    ) wdut (
        .clk   (clk),
        .reset (reset),
        .bus   (wbus)
    );

    typedef struct packed {
        logic [9:0] pc;
        logic [3:0] sp;
        logic       in_isr;
        logic [3:0] ack;
        logic       ovf;
        logic       unf;
    } exp_t;

    typedef struct packed {
        logic [3:0] pc;
        logic [1:0] sp;
        logic [1:0] ack;
    } wexp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    wexp_t wexp_q[$];
    string wtag_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_pulses();
        bus.s_inc  = 1'b1;
        bus.call   = 1'b0;
        bus.ret    = 1'b0;
        bus.reti   = 1'b0;
        bus.ie_set = 1'b0;
        bus.ie_clr = 1'b0;
        wbus.s_inc  = 1'b1;
        wbus.call   = 1'b0;
        wbus.ret    = 1'b0;
        wbus.reti   = 1'b0;
        wbus.ie_set = 1'b0;
        wbus.ie_clr = 1'b0;
    endtask

    // Queue the expected state, clock once, then pop and compare against the main DUT.
    task automatic step(input string tag, input logic [9:0] pc, input logic [3:0] sp,
                        input logic isr, input logic [3:0] ack, input logic ovf, input logic unf);
        exp_t  e;
        string t;
        e.pc = pc; e.sp = sp; e.in_isr = isr; e.ack = ack; e.ovf = ovf; e.unf = unf;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        clear_pulses();
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check_eq({t, ".pc"},      32'(bus.pc),        32'(e.pc));
        check_eq({t, ".sp"},      32'(bus.sp),        32'(e.sp));
        check_eq({t, ".in_isr"},  32'(bus.in_isr),    32'(e.in_isr));
        check_eq({t, ".irq_ack"}, 32'(bus.irq_ack),   32'(e.ack));
        check_eq({t, ".ovf"},     32'(bus.stack_ovf), 32'(e.ovf));
        check_eq({t, ".unf"},     32'(bus.stack_unf), 32'(e.unf));
    endtask

    // Same for the narrow build.
    task automatic step_w(input string tag, input logic [3:0] pc, input logic [1:0] sp,
                          input logic [1:0] ack);
        wexp_t e;
        string t;
        e.pc = pc; e.sp = sp; e.ack = ack;
        wexp_q.push_back(e);
        wtag_q.push_back(tag);
        @(posedge clk);
        #1;
        clear_pulses();
        e = wexp_q.pop_front();
        t = wtag_q.pop_front();
        check_eq({t, ".pc"},      32'(wbus.pc),      32'(e.pc));
        check_eq({t, ".sp"},      32'(wbus.sp),      32'(e.sp));
        check_eq({t, ".irq_ack"}, 32'(wbus.irq_ack), 32'(e.ack));
    endtask

    initial begin
        reset = 1'b0;
        clear_pulses();
        bus.jump_addr  = '0;
        bus.irq        = '0;
        bus.irq_mask   = '0;
        wbus.jump_addr = '0;
        wbus.irq       = '0;
        wbus.irq_mask  = '0;

        // Reset and sequential flow
        step("rst0", 10'h000, 0, 0, 0, 0, 0);
        step("rst1", 10'h000, 0, 0, 0, 0, 0);
        reset = 1'b1;
        for (int k = 1; k <= 5; k++) step($sformatf("seq%0d", k), 10'(k), 0, 0, 0, 0, 0);

        // Call / return
        bus.s_inc = 1'b0; bus.jump_addr = 10'h010;
        step("jmp10", 10'h010, 0, 0, 0, 0, 0);
        bus.call = 1'b1; bus.jump_addr = 10'h200;
        step("call", 10'h200, 1, 0, 0, 0, 0);
        bus.ret = 1'b1;
        step("ret", 10'h011, 0, 0, 0, 0, 0);

        // Overflow: DEPTH+1 calls
        for (int k = 0; k <= 8; k++) begin
            bus.call = 1'b1; bus.jump_addr = 10'h100 + 10'(k);
            step($sformatf("ocall%0d", k), 10'h100 + 10'(k), (k < 8) ? 4'(k + 1) : 4'd8,
                 0, 0, (k == 8), 0);
        end
        // Underflow: DEPTH+1 returns from full
        for (int j = 0; j <= 8; j++) begin
            bus.ret = 1'b1;
            if (j < 8)
                step($sformatf("uret%0d", j), (j == 7) ? 10'h012 : 10'h100 + 10'(7 - j),
                     4'(7 - j), 0, 0, 1, 0);
            else
                step("uret8", 10'h013, 0, 0, 0, 1, 1);
        end

        // Reset with sticky flags set
        reset = 1'b0;
        step("rst_mid", 10'h000, 0, 0, 0, 0, 0);
        reset = 1'b1;

        // Interrupt take, one-cycle ack, reti, then the second line
        bus.irq_mask = 4'hF; bus.ie_set = 1'b1; bus.s_inc = 1'b0; bus.jump_addr = 10'h020;
        step("to20", 10'h020, 0, 0, 0, 0, 0);
        bus.irq = 4'b0110;
        step("pend", 10'h021, 0, 0, 0, 0, 0);
        step("take1", 10'h388, 1, 1, 4'b0010, 0, 0);
        step("isr1", 10'h389, 1, 1, 0, 0, 0);
        bus.irq = 4'b0000; bus.reti = 1'b1;
        step("reti1", 10'h022, 0, 0, 0, 0, 0);
        step("take2", 10'h38C, 1, 1, 4'b0100, 0, 0);
        bus.reti = 1'b1;
        step("reti2", 10'h023, 0, 0, 0, 0, 0);

        // Blocked by ie=0
        bus.ie_clr = 1'b1;
        step("ieclr", 10'h024, 0, 0, 0, 0, 0);
        bus.irq = 4'b0001;
        for (int k = 5; k <= 8; k++) step($sformatf("ieoff%0d", k), 10'h020 + 10'(k), 0, 0, 0, 0, 0);
        bus.ie_set = 1'b1;
        step("ieset", 10'h029, 0, 0, 0, 0, 0);
        step("take_ie", 10'h384, 1, 1, 4'b0001, 0, 0);
        bus.reti = 1'b1;
        step("reti_ie", 10'h02A, 0, 0, 0, 0, 0);

        // Blocked by mask
        bus.irq_mask = 4'b0000; bus.irq = 4'b1000;
        step("mask_a", 10'h02B, 0, 0, 0, 0, 0);
        step("mask_b", 10'h02C, 0, 0, 0, 0, 0);
        step("mask_c", 10'h02D, 0, 0, 0, 0, 0);
        bus.irq_mask = 4'b1000;
        step("take_mask", 10'h390, 1, 1, 4'b1000, 0, 0);

        // Blocked by in_isr
        bus.irq_mask = 4'hF; bus.irq = 4'b1010;
        step("nest_a", 10'h391, 1, 1, 0, 0, 0);
        step("nest_b", 10'h392, 1, 1, 0, 0, 0);
        bus.reti = 1'b1;
        step("reti_c", 10'h02E, 0, 0, 0, 0, 0);
        step("take_nest", 10'h388, 1, 1, 4'b0010, 0, 0);
        bus.reti = 1'b1;
        step("reti_c2", 10'h02F, 0, 0, 0, 0, 0);

        // Blocked by full stack
        for (int k = 0; k < 8; k++) begin
            bus.call = 1'b1; bus.jump_addr = 10'h300 + 10'(k);
            step($sformatf("fcall%0d", k), 10'h300 + 10'(k), 4'(k + 1), 0, 0, 0, 0);
        end
        bus.irq = 4'b0100;
        step("full_a", 10'h308, 8, 0, 0, 0, 0);
        step("full_b", 10'h309, 8, 0, 0, 0, 0);
        bus.ret = 1'b1;
        step("full_ret", 10'h307, 7, 0, 0, 0, 0);
        step("take_full", 10'h38C, 8, 1, 4'b0100, 0, 0);
        bus.reti = 1'b1;
        step("reti_d", 10'h308, 7, 0, 0, 0, 0);

        // Take coinciding with call: call target becomes the resume address
        bus.irq = 4'b0001;
        step("pend_e", 10'h309, 7, 0, 0, 0, 0);
        bus.call = 1'b1; bus.jump_addr = 10'h155;
        step("take_call", 10'h384, 8, 1, 4'b0001, 0, 0);
        bus.reti = 1'b1;
        step("reti_e", 10'h155, 7, 0, 0, 0, 0);

        // ie_clr wins over ie_set
        bus.ie_set = 1'b1; bus.ie_clr = 1'b1;
        step("ie_both", 10'h156, 7, 0, 0, 0, 0);
        bus.irq = 4'b0010;
        step("ie_off_a", 10'h157, 7, 0, 0, 0, 0);
        step("ie_off_b", 10'h158, 7, 0, 0, 0, 0);

        // Narrow build: PC wrap and truncated vector (0xE + 1*3 -> 0x1)
        wbus.s_inc = 1'b0; wbus.jump_addr = 4'hF;
        step_w("w_jmpF", 4'hF, 0, 0);
        wbus.ie_set = 1'b1;
        step_w("w_wrap", 4'h0, 0, 0);
        wbus.irq_mask = 2'b11; wbus.irq = 2'b10;
        step_w("w_pend", 4'h1, 0, 0);
        step_w("w_take", 4'h1, 1, 2'b10);
        wbus.reti = 1'b1;
        step_w("w_reti", 4'h2, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
